hough_peak_select: RTL and testbench
====================================

// Module: hough_peak_select
// PURPOSE
//  Streaming peak finder for the Hough accumulator read-out. Consumes LANES theta-adjacent vote counts per beat,
//  tracks the strongest bin inside a left-lane and a right-lane theta window, reports signed rho / theta / votes
//  per side. Sits after the accumulator BRAM read-out in hough_top and feeds the line-draw stage.
// PARAMETERS
//  LANES        4     vote counts per beat (theta unroll)
//  COUNT_W      16    vote-count width
//  THETA_BITS   8     theta index width
//  RHO_IDX_W    12    unsigned rho index width
//  RHOS         1468  rho offset; signed rho = rho_idx - RHOS
//  THETAS       180   theta bins; lanes with theta >= THETAS ignored
//  LEFT_LO/HI   100/170   left window, inclusive
//  RIGHT_LO/HI  10/80     right window, inclusive
// PORTS
//  clock        in   1                    clock
//  reset        in   1                    reset, asynchronous, active-low
//  start        in   1                    pulse: clear trackers, enter SCAN
//  in_valid     in   1                    beat valid
//  in_ready     out  1                    high only in SCAN
//  in_last      in   1                    final beat of scan
//  in_rho_idx   in   RHO_IDX_W            rho index of beat
//  in_theta     in   THETA_BITS           theta of lane 0; lane j = in_theta + j
//  in_data      in   LANES*COUNT_W        vote counts, lane 0 in LSBs
//  busy         out  1                    SCAN or REDUCE
//  done         out  1                    one-cycle pulse, results valid
//  left_found / right_found   out 1       side had a qualifying bin
//  left_rho / right_rho       out 16 signed
//  left_theta / right_theta   out THETA_BITS
//  left_votes / right_votes   out COUNT_W
//  min_votes    in   COUNT_W              only with HOUGH_MIN_VOTES_EN
// BEHAVIOUR
//  Reset: state IDLE; in_ready, busy, done, *_found = 0; rho, theta, votes = 0.
//  FSM IDLE -start-> SCAN -(in_valid&in_last accepted)-> REDUCE -(pipeline drained)-> DONE -> IDLE.
//  Beat accepted iff in_valid & in_ready; in_valid outside SCAN ignored, no side effects.
//  Stage 1 (registered): per side, max over lanes whose theta falls in the window; lower lane wins ties.
//  Stage 2 (registered): update running best iff stage-1 max > best votes (strict) and max qualifies;
//   earliest beat wins ties -> lowest rho_idx, then lowest theta.
//  Qualify: votes > 0 (default build). Zero-vote bins never set *_found.
//  Latency: last beat accepted in cycle N -> done high in N+2, outputs updated the same cycle.
//  Outputs hold until the next start; start clears trackers, *_found and outputs to 0 next cycle.
//  start in any non-IDLE state: abort, clear, re-enter SCAN; no done pulse for the aborted scan.
//  start and accepted beat in same cycle: start wins, beat dropped.
//  in_last on first beat legal (single-beat scan). Theta add saturates: lane with in_theta+j >= THETAS masked.
//  rho arithmetic in 17 bits, truncated to 16 signed; RHOS chosen so result fits.
//  Reset asserted mid-scan: immediate return to reset values, no done.
// CONFIGURATION
//  HOUGH_MIN_VOTES_EN defined: min_votes port present; qualify = votes >= min_votes (min_votes sampled at start,
//   held for scan). Undefined: port absent, qualify = votes > 0.
// STRUCTURE
//  hough_pkg: peak_t struct {found, rho_idx, theta, votes}, state_t enum, window compare function.
//  Sub-module hough_lane_max: one instance per side; LANES-wide masked max, registered, emits peak_t.
// TESTING
//  1. start, 1 beat rho_idx=1305 theta=128 data={0,0,0,9}(lane0=9), last -> done N+2, left rho=-163 theta=128 votes=9, right_found=0.
//  2. beat rho_idx=2043 theta=60 lane0=7 then beat rho_idx=2043 theta=64 lane2=7 -> right rho=575 theta=60 (first wins).
//  3. all-zero scan 734x45 beats -> done, both found=0, rho/theta/votes 0.
//  4. theta=176 lanes 176..179 valid, next beat theta=180 lanes masked with data 99 -> ignored, no found.
//  5. start mid-SCAN after 10 beats holding votes 50 -> no done; new scan max 3 reports 3.
//  6. HOUGH_MIN_VOTES_EN, min_votes=20, peak 19 -> found=0; peak 20 -> found=1 votes=20.

Source files
------------

// File: rtl/hough_pkg.sv
// Shared types and helpers for the Hough peak-select block.
package hough_pkg;

    localparam int COUNT_W    = 16;
    localparam int THETA_BITS = 8;
    localparam int RHO_IDX_W  = 12;
    localparam int RHO_W      = 16;

    typedef struct packed {
        logic                  found;
        logic [RHO_IDX_W-1:0]  rho_idx;
        logic [THETA_BITS-1:0] theta;
        logic [COUNT_W-1:0]    votes;
    } peak_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REDUCE,
        ST_DONE
    } state_t;

    function automatic logic in_window(input int unsigned theta,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (theta >= lo) && (theta <= hi);
    endfunction

endpackage

// File: rtl/hough_lane_max.sv
// Registered max over the LANES vote counts of one beat whose theta lands inside one side's window.
module hough_lane_max
    import hough_pkg::*;
#(
    parameter int          LANES  = 4,
    parameter int unsigned THETAS = 180,
    parameter int unsigned WIN_LO = 100,
    parameter int unsigned WIN_HI = 170
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  logic [RHO_IDX_W-1:0]     rho_idx_i,
    input  logic [THETA_BITS-1:0]    theta_i,
    input  logic [LANES*COUNT_W-1:0] data_i,
    output peak_t                    peak_o
);

    // Wide enough that in_theta + lane never wraps, so out-of-range lanes are masked, not aliased.
    localparam int TW = THETA_BITS + $clog2(LANES) + 1;

    peak_t           peak_d;
    peak_t           peak_q;
    logic [TW-1:0]   lane_theta;
    logic [COUNT_W-1:0] lane_votes;

    always_comb begin
        peak_d     = '0;
        lane_theta = '0;
        lane_votes = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_theta = TW'(theta_i) + TW'(j);
            lane_votes = data_i[j*COUNT_W +: COUNT_W];
            // Strict compare keeps the lowest lane on ties.
            if (valid_i && (32'(lane_theta) < THETAS) &&
                in_window(32'(lane_theta), WIN_LO, WIN_HI) &&
                (!peak_d.found || (lane_votes > peak_d.votes))) begin
                peak_d.found   = 1'b1;
                peak_d.rho_idx = rho_idx_i;
                peak_d.theta   = lane_theta[THETA_BITS-1:0];
                peak_d.votes   = lane_votes;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            peak_q <= '0;
        end else if (clear_i) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/hough_peak_select.sv
// Streaming left/right peak finder over the Hough accumulator read-out.
// HOUGH_MIN_VOTES_EN adds a min_votes_i threshold sampled at start.
//
//  state     | meaning
//  ST_IDLE   | waiting for start, results held
//  ST_SCAN   | accepting beats, running best per side
//  ST_REDUCE | last beat in stage 1, folding into best
//  ST_DONE   | done pulse, results valid
module hough_peak_select
    import hough_pkg::*;
#(
    parameter int          LANES    = 4,
    parameter int          RHOS     = 1468,
    parameter int unsigned THETAS   = 180,
    parameter int unsigned LEFT_LO  = 100,
    parameter int unsigned LEFT_HI  = 170,
    parameter int unsigned RIGHT_LO = 10,
    parameter int unsigned RIGHT_HI = 80
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        in_last_i,
    input  logic [RHO_IDX_W-1:0]        in_rho_idx_i,
    input  logic [THETA_BITS-1:0]       in_theta_i,
    input  logic [LANES*COUNT_W-1:0]    in_data_i,
`ifdef HOUGH_MIN_VOTES_EN
    input  logic [COUNT_W-1:0]          min_votes_i,
`endif
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        left_found_o,
    output logic                        right_found_o,
    output logic signed [RHO_W-1:0]     left_rho_o,
    output logic signed [RHO_W-1:0]     right_rho_o,
    output logic [THETA_BITS-1:0]       left_theta_o,
    output logic [THETA_BITS-1:0]       right_theta_o,
    output logic [COUNT_W-1:0]          left_votes_o,
    output logic [COUNT_W-1:0]          right_votes_o
);

    state_t state_q;
    logic   in_ready_q;
    logic   busy_q;
    logic   done_q;
    logic   beat_acc;
    peak_t  s1_l;
    peak_t  s1_r;
    peak_t  best_l_q, best_l_d;
    peak_t  best_r_q, best_r_d;
    peak_t  res_l_q;
    peak_t  res_r_q;
    logic signed [RHO_W-1:0] rho_l_q;
    logic signed [RHO_W-1:0] rho_r_q;
    logic   qual_l;
    logic   qual_r;

    // 16-bit modular subtract gives the same bits as the 17-bit difference truncated to 16.
    function automatic logic signed [RHO_W-1:0] to_rho(input peak_t p);
        logic [RHO_W-1:0] r;
        r = RHO_W'(p.rho_idx) - RHO_W'(RHOS);
        return p.found ? $signed(r) : '0;
    endfunction

    assign beat_acc = in_valid_i & in_ready_q & ~start_i;

    hough_lane_max #(
        .LANES  (LANES),
        .THETAS (THETAS),
        .WIN_LO (LEFT_LO),
        .WIN_HI (LEFT_HI)
    ) u_left (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (start_i),
        .valid_i   (beat_acc),
        .rho_idx_i (in_rho_idx_i),
        .theta_i   (in_theta_i),
        .data_i    (in_data_i),
        .peak_o    (s1_l)
    );

    hough_lane_max #(
        .LANES  (LANES),
        .THETAS (THETAS),
        .WIN_LO (RIGHT_LO),
        .WIN_HI (RIGHT_HI)
    ) u_right (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (start_i),
        .valid_i   (beat_acc),
        .rho_idx_i (in_rho_idx_i),
        .theta_i   (in_theta_i),
        .data_i    (in_data_i),
        .peak_o    (s1_r)
    );

`ifdef HOUGH_MIN_VOTES_EN
    logic [COUNT_W-1:0] min_votes_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            min_votes_q <= '0;
        end else if (start_i) begin
            min_votes_q <= min_votes_i;
        end
    end

    assign qual_l = (s1_l.votes != '0) && (s1_l.votes >= min_votes_q);
    assign qual_r = (s1_r.votes != '0) && (s1_r.votes >= min_votes_q);
`else
    assign qual_l = (s1_l.votes != '0);
    assign qual_r = (s1_r.votes != '0);
`endif

    // Strict compare: the earliest beat holding the max keeps the slot.
    always_comb begin
        best_l_d = best_l_q;
        best_r_d = best_r_q;
        if (s1_l.found && qual_l && (s1_l.votes > best_l_q.votes)) begin
            best_l_d = s1_l;
        end
        if (s1_r.found && qual_r && (s1_r.votes > best_r_q.votes)) begin
            best_r_d = s1_r;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            best_l_q   <= '0;
            best_r_q   <= '0;
            res_l_q    <= '0;
            res_r_q    <= '0;
            rho_l_q    <= '0;
            rho_r_q    <= '0;
        end else begin
            done_q   <= 1'b0;
            best_l_q <= best_l_d;
            best_r_q <= best_r_d;
            if (start_i) begin
                state_q    <= ST_SCAN;
                in_ready_q <= 1'b1;
                busy_q     <= 1'b1;
                best_l_q   <= '0;
                best_r_q   <= '0;
                res_l_q    <= '0;
                res_r_q    <= '0;
                rho_l_q    <= '0;
                rho_r_q    <= '0;
            end else begin
                case (state_q)
                    ST_SCAN: begin
                        if (beat_acc && in_last_i) begin
                            state_q    <= ST_REDUCE;
                            in_ready_q <= 1'b0;
                        end
                    end
                    ST_REDUCE: begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_l_q <= best_l_d;
                        res_r_q <= best_r_d;
                        rho_l_q <= to_rho(best_l_d);
                        rho_r_q <= to_rho(best_r_d);
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready_o    = in_ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign left_found_o  = res_l_q.found;
    assign right_found_o = res_r_q.found;
    assign left_rho_o    = rho_l_q;
    assign right_rho_o   = rho_r_q;
    assign left_theta_o  = res_l_q.theta;
    assign right_theta_o = res_r_q.theta;
    assign left_votes_o  = res_l_q.votes;
    assign right_votes_o = res_r_q.votes;

endmodule

// File: tb/tb_hough_peak_select.sv
// Scoreboard bench for hough_peak_select; expected peaks come from a per-lane reference model.
module tb_hough_peak_select;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_last_i = 1'b0;
    logic [11:0] in_rho_idx_i = '0;
    logic [7:0]  in_theta_i = '0;
    logic [63:0] in_data_i = '0;
`ifdef HOUGH_MIN_VOTES_EN
    logic [15:0] min_votes_i = '0;
`endif
    logic               in_ready_o, busy_o, done_o, left_found_o, right_found_o;
    logic signed [15:0] left_rho_o, right_rho_o;
    logic [7:0]         left_theta_o, right_theta_o;
    logic [15:0]        left_votes_o, right_votes_o;

    typedef struct {bit found; int rho_idx; int theta; int votes;} mpk_t;
    typedef struct {mpk_t l; mpk_t r;} exp_t;

    exp_t sb[$];
    mpk_t ml, mr;
    int   mmin = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    hough_peak_select dut (
        .clock         (clock),
        .reset         (reset),
        .start_i       (start_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_last_i     (in_last_i),
        .in_rho_idx_i  (in_rho_idx_i),
        .in_theta_i    (in_theta_i),
        .in_data_i     (in_data_i),
`ifdef HOUGH_MIN_VOTES_EN
        .min_votes_i   (min_votes_i),
`endif
        .busy_o        (busy_o),
        .done_o        (done_o),
        .left_found_o  (left_found_o),
        .right_found_o (right_found_o),
        .left_rho_o    (left_rho_o),
        .right_rho_o   (right_rho_o),
        .left_theta_o  (left_theta_o),
        .right_theta_o (right_theta_o),
        .left_votes_o  (left_votes_o),
        .right_votes_o (right_votes_o)
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic mdl_clear();
        ml = '{0, 0, 0, 0};
        mr = '{0, 0, 0, 0};
    endtask

    task automatic mdl_beat(input int rho, input int th, input logic [63:0] d);
        for (int j = 0; j < 4; j++) begin
            int t;
            int v;
            t = th + j;
            v = int'(d[j*16 +: 16]);
            if (t < 180 && v > 0 && v >= mmin) begin
                if (t >= 100 && t <= 170 && v > ml.votes) ml = '{1, rho, t, v};
                if (t >= 10 && t <= 80 && v > mr.votes) mr = '{1, rho, t, v};
            end
        end
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic do_start();
        start_i = 1'b1;
`ifdef HOUGH_MIN_VOTES_EN
        mmin = int'(min_votes_i);
`endif
        mdl_clear();
        @(negedge clock);
        start_i = 1'b0;
    endtask

    task automatic beat(input int rho, input int th, input logic [63:0] d, input bit last);
        in_valid_i   = 1'b1;
        in_last_i    = last;
        in_rho_idx_i = 12'(rho);
        in_theta_i   = 8'(th);
        in_data_i    = d;
        mdl_beat(rho, th, d);
        if (last) sb.push_back('{ml, mr});
        @(negedge clock);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        if (last) check("done_early", done_o, 0);
    endtask

    task automatic wait_done();
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done_o && n < 50);
        if (!done_o) begin
            check("done_timeout", 0, 1);
            void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
        end else begin
            e = sb.pop_front();
            check("done_latency", n, 1);
            check("left_found", left_found_o, e.l.found);
            check("left_rho", left_rho_o, e.l.found ? e.l.rho_idx - 1468 : 0);
            check("left_theta", left_theta_o, e.l.theta);
            check("left_votes", left_votes_o, e.l.votes);
            check("right_found", right_found_o, e.r.found);
            check("right_rho", right_rho_o, e.r.found ? e.r.rho_idx - 1468 : 0);
            check("right_theta", right_theta_o, e.r.theta);
            check("right_votes", right_votes_o, e.r.votes);
            @(negedge clock);
            check("done_pulse_width", done_o, 0);
            check("busy_after_done", busy_o, 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        #1;
        check("rst_in_ready", in_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_left_found", left_found_o, 0);
        check("rst_right_found", right_found_o, 0);
        check("rst_left_rho", left_rho_o, 0);
        check("rst_left_votes", left_votes_o, 0);
        #20;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // single-beat scan, left window
        do_start();
        check("scan_busy", busy_o, 1);
        check("scan_in_ready", in_ready_o, 1);
        beat(1305, 128, 64'd9, 1);
        wait_done();
        check("idle_in_ready", in_ready_o, 0);

        // in_valid outside SCAN has no effect
        seen = 0;
        in_valid_i = 1'b1; in_last_i = 1'b1; in_theta_i = 8'd128; in_data_i = 64'd500;
        repeat (3) begin
            @(negedge clock);
            if (done_o || busy_o) seen = 1;
        end
        in_valid_i = 1'b0; in_last_i = 1'b0;
        check("idle_beat_ignored", seen, 0);
        check("idle_hold_votes", left_votes_o, 9);

        // equal votes: first beat keeps the slot
        do_start();
        beat(2043, 60, 64'd7, 0);
        beat(2043, 64, 64'd7 << 32, 1);
        wait_done();

        // lanes 176..179 outside both windows, theta 180 lanes masked
        do_start();
        beat(100, 176, {16'd5, 16'd6, 16'd7, 16'd8}, 0);
        beat(101, 180, {16'd99, 16'd99, 16'd99, 16'd99}, 1);
        wait_done();

        // lane tie inside one beat: lower lane wins
        do_start();
        beat(700, 110, {16'd4, 16'd12, 16'd12, 16'd1}, 0);
        beat(900, 20, {16'd12, 16'd3, 16'd3, 16'd3}, 1);
        wait_done();

        // random scans
        for (int s = 0; s < 5; s++) begin
            do_start();
            for (int b = 0; b < 40; b++) begin
                logic [63:0] d;
                for (int j = 0; j < 4; j++) d[j*16 +: 16] = 16'($urandom_range(0, 31));
                beat($urandom_range(0, 2935), $urandom_range(0, 185), d, b == 39);
            end
            wait_done();
        end

        // abort mid-scan with a same-cycle beat; that beat must be dropped
        do_start();
        check("start_clears_left", left_found_o, 0);
        check("start_clears_right_votes", right_votes_o, 0);
        for (int b = 0; b < 10; b++) beat(200 + b, 100, 64'd50, 0);
        start_i = 1'b1; in_valid_i = 1'b1; in_last_i = 1'b1;
        in_rho_idx_i = 12'd300; in_theta_i = 8'd120; in_data_i = 64'd77;
        mdl_clear();
        @(negedge clock);
        start_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (done_o) seen = 1;
        end
        check("abort_no_done", seen, 0);
        check("abort_still_busy", busy_o, 1);
        beat(500, 100, 64'd3 << 16, 0);
        beat(501, 30, 64'd2, 1);
        wait_done();

        // all-zero full scan
        do_start();
        for (int r = 0; r < 734; r++)
            for (int t = 0; t < 45; t++)
                beat(r, t * 4, 64'd0, (r == 733) && (t == 44));
        wait_done();

        // reset asserted mid-scan
        do_start();
        beat(1500, 120, 64'd40, 0);
        beat(1501, 40, 64'd41, 0);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_in_ready", in_ready_o, 0);
        check("midrst_left_votes", left_votes_o, 0);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (done_o) seen = 1;
        end
        check("midrst_no_done", seen, 0);

`ifdef HOUGH_MIN_VOTES_EN
        min_votes_i = 16'd20;
        do_start();
        beat(1400, 130, 64'd19, 1);
        wait_done();
        do_start();
        beat(1400, 130, 64'd20, 1);
        wait_done();
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
